// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: memory map defaults,
// FSM state encodings and requester IDs.
package mem_arbiter_pkg;

   localparam logic [31:0] ENTRY_DEFAULT     = 32'h8000_0000;
   localparam int          MEM_WORDS_DEFAULT = 2056;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_addr_map.sv
// Byte address to word index translation relative to ENTRY, with range check.
module mem_addr_map
   import mem_arbiter_pkg::*;
#(
   parameter logic [31:0] ENTRY     = ENTRY_DEFAULT,
   parameter int          MEM_WORDS = MEM_WORDS_DEFAULT
)(
   input  logic [31:0] i_addr,
   output logic [31:0] o_idx,
   output logic        o_in_range
);

   localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);

   logic [31:0] w_offset;

   assign w_offset   = i_addr - ENTRY;
   assign o_idx      = w_offset >> 2;
   // Addresses below ENTRY wrap to large offsets, so both bounds are checked.
   assign o_in_range = (i_addr >= ENTRY) && (w_offset < SPAN);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one word memory: D has priority,
// a starvation counter forces an I grant after STARVE_MAX back-to-back D grants.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [31:0] ENTRY      = ENTRY_DEFAULT,
   parameter int          MEM_WORDS  = MEM_WORDS_DEFAULT,
   parameter int          MEM_LAT    = 1,
   parameter int          STARVE_MAX = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_wstrb,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_idx,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] LAT_LOAD   = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   arb_state_t  r_state, w_state_next;
   logic [3:0]  r_lat_cnt;
   logic [2:0]  r_starve;
   logic        r_win;
   logic        r_we;
   logic [3:0]  r_wstrb;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] w_idx;
   logic        w_in_range;
   logic        w_pick_i;

   mem_addr_map #(
      .ENTRY     (ENTRY),
      .MEM_WORDS (MEM_WORDS)
   ) u_addr_map (
      .i_addr     (r_addr),
      .o_idx      (w_idx),
      .o_in_range (w_in_range)
   );

   assign w_pick_i = i_req && (!d_req || (r_starve == STARVE_LIM));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_lat_cnt <= 4'd0;
         r_starve  <= 3'd0;
         r_win     <= REQ_I;
         r_we      <= 1'b0;
         r_wstrb   <= 4'd0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  if (w_pick_i) begin
                     r_win   <= REQ_I;
                     r_addr  <= i_addr;
                     r_we    <= 1'b0;
                     r_wstrb <= 4'd0;
                     r_wdata <= 32'd0;
                  end else begin
                     r_win   <= REQ_D;
                     r_addr  <= d_addr;
                     r_we    <= d_we;
                     r_wstrb <= d_we ? d_wstrb : 4'd0;
                     r_wdata <= d_wdata;
                  end
               end
            end
            ST_ISSUE: begin
               r_lat_cnt <= LAT_LOAD;
               // Only a D grant with fetch still waiting counts towards starvation.
               if ((r_win == REQ_I) || !i_req) begin
                  r_starve <= 3'd0;
               end else if (r_starve != STARVE_LIM) begin
                  r_starve <= r_starve + 3'd1;
               end
            end
            ST_WAIT: begin
               if (r_lat_cnt != 4'd0) begin
                  r_lat_cnt <= r_lat_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      i_gnt        = 1'b0;
      i_rvalid     = 1'b0;
      i_rdata      = 32'd0;
      i_err        = 1'b0;
      d_gnt        = 1'b0;
      d_rvalid     = 1'b0;
      d_rdata      = 32'd0;
      d_err        = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_wstrb    = 4'd0;
      mem_idx      = 32'd0;
      mem_wdata    = 32'd0;
      case (r_state)
         ST_IDLE: begin
            if (i_req || d_req) begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            i_gnt = (r_win == REQ_I);
            d_gnt = (r_win == REQ_D);
            if (w_in_range) begin
               mem_en       = 1'b1;
               mem_we       = r_we;
               mem_wstrb    = r_wstrb;
               mem_idx      = w_idx;
               mem_wdata    = r_wdata;
               w_state_next = (MEM_LAT > 1) ? ST_WAIT : ST_RESP;
            end else begin
               w_state_next = ST_RESP;
            end
         end
         ST_WAIT: begin
            if (r_lat_cnt == 4'd0) begin
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            // r_addr is still held, so the range flag here matches the one seen at issue.
            if (r_win == REQ_I) begin
               i_rvalid = 1'b1;
               i_err    = !w_in_range;
               i_rdata  = w_in_range ? mem_rdata : 32'd0;
            end else begin
               d_rvalid = 1'b1;
               d_err    = !w_in_range;
               d_rdata  = (w_in_range && !r_we) ? mem_rdata : 32'd0;
            end
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;

   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
   logic [31:0] i_rdata, d_rdata;
   logic        mem_en, mem_we;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_idx, mem_wdata, mem_rdata;

   logic        b_i_req, b_d_req, b_d_we;
   logic [31:0] b_i_addr, b_d_addr, b_d_wdata;
   logic [3:0]  b_d_wstrb;
   logic        b_i_gnt, b_i_rvalid, b_i_err, b_d_gnt, b_d_rvalid, b_d_err;
   logic [31:0] b_i_rdata, b_d_rdata;
   logic        b_mem_en, b_mem_we;
   logic [3:0]  b_mem_wstrb;
   logic [31:0] b_mem_idx, b_mem_wdata, b_mem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_idx(mem_idx),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .reset(reset),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid),
      .i_rdata(b_i_rdata), .i_err(b_i_err),
      .d_req(b_d_req), .d_we(b_d_we), .d_wstrb(b_d_wstrb), .d_addr(b_d_addr),
      .d_wdata(b_d_wdata), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .d_err(b_d_err),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_wstrb(b_mem_wstrb), .mem_idx(b_mem_idx),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   // Memory models: word k preloads to a known pattern; read data appears
   // exactly MEM_LAT cycles after the mem_en cycle, junk otherwise.
   logic [31:0] mem1 [0:63];
   logic [31:0] mem3 [0:63];
   logic [31:0] p1;
   logic [31:0] p3 [0:2];
   bit          mem_ready;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int k = 0; k < 64; k++) begin
            mem1[k] <= 32'hA5A5_0000 | 32'(k);
            mem3[k] <= 32'h3C3C_0000 | 32'(k);
         end
         mem_ready <= 1'b1;
      end else begin
         if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) mem1[mem_idx[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         if (b_mem_en && b_mem_we)
            for (int b = 0; b < 4; b++)
               if (b_mem_wstrb[b]) mem3[b_mem_idx[5:0]][8*b +: 8] <= b_mem_wdata[8*b +: 8];
      end
      p1    <= mem_en ? mem1[mem_idx[5:0]] : 32'hBAD0_BAD0;
      p3[0] <= b_mem_en ? mem3[b_mem_idx[5:0]] : 32'hBAD0_BAD0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   assign mem_rdata   = p1;
   assign b_mem_rdata = p3[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Grant and response exclusivity on both instances, every cycle.
   always @(negedge clk) begin
      if (!reset) begin
         chk("gnt_excl",    32'(i_gnt & d_gnt), 32'd0);
         chk("rvalid_excl", 32'(i_rvalid & d_rvalid), 32'd0);
         chk("gnt_excl3",   32'(b_i_gnt & b_d_gnt), 32'd0);
      end
   end

   logic [9:0] seq;
   int         n_gnt;
   int         n_ii;
   logic       prev_i;
   int         n_rv;

   initial begin
      reset = 1'b1;
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
      b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_wstrb = 0;
      b_d_addr = 0; b_d_wdata = 0;
      tick(); tick();
      chk("rst_ctl", 32'({i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_en, mem_we, mem_wstrb}), 32'd0);
      chk("rst_data", i_rdata | d_rdata | mem_idx | mem_wdata, 32'd0);
      reset = 1'b0;
      tick();

      // Fetch, MEM_LAT=1
      i_req = 1; i_addr = 32'h8000_0010;
      tick();
      chk("f_igni", 32'(i_gnt), 32'd1);
      chk("f_men", 32'(mem_en), 32'd1);
      chk("f_idx", mem_idx, 32'd4);
      chk("f_mwe", 32'(mem_we), 32'd0);
      i_req = 0;
      tick();
      chk("f_rv", 32'(i_rvalid), 32'd1);
      chk("f_rdata", i_rdata, 32'hA5A5_0004);
      chk("f_err", 32'(i_err), 32'd0);
      $display("txn fetch addr=80000010 rdata=%h", i_rdata);
      tick();
      chk("f_idle", 32'(i_rvalid), 32'd0);

      // Partial write then read-back
      d_req = 1; d_we = 1; d_wstrb = 4'b0011; d_addr = 32'h8000_0008; d_wdata = 32'hDEAD_BEEF;
      tick();
      chk("w_dgnt", 32'(d_gnt), 32'd1);
      chk("w_mctl", 32'({mem_en, mem_we, mem_wstrb}), 32'b1_1_0011);
      chk("w_idx", mem_idx, 32'd2);
      chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
      d_req = 0;
      tick();
      chk("w_rv", 32'({d_rvalid, d_err}), 32'b10);
      chk("w_rdata", d_rdata, 32'd0);
      $display("txn write addr=80000008 wstrb=0011 wdata=deadbeef");
      tick();
      d_req = 1; d_we = 0; d_wstrb = 0;
      tick();
      chk("rb_gnt", 32'({d_gnt, mem_en, mem_we}), 32'b110);
      d_req = 0;
      tick();
      chk("rb_rv", 32'(d_rvalid), 32'd1);
      chk("rb_low", 32'(d_rdata[15:0]), 32'h0000_BEEF);
      chk("rb_word", d_rdata, 32'hA5A5_BEEF);
      $display("txn read addr=80000008 rdata=%h", d_rdata);
      tick();

      // Both requesters held: D,D,D,D,I,D,D,D,D,I
      i_req = 1; i_addr = 32'h8000_0000;
      d_req = 1; d_we = 0; d_addr = 32'h8000_0004;
      seq = '0; n_gnt = 0; n_ii = 0; prev_i = 0;
      for (int c = 0; c < 60 && n_gnt < 10; c++) begin
         tick();
         if (i_gnt || d_gnt) begin
            seq = {seq[8:0], d_gnt};
            if (i_gnt && prev_i) n_ii++;
            prev_i = i_gnt;
            n_gnt++;
            $display("txn grant %0d to %s", n_gnt, d_gnt ? "D" : "I");
            if (n_gnt == 10) begin
               i_req = 0; d_req = 0;
            end
         end
      end
      i_req = 0; d_req = 0;
      chk("st_count", 32'(n_gnt), 32'd10);
      chk("st_seq", 32'(seq), 32'(10'b1111011110));
      chk("st_no_ii", 32'(n_ii), 32'd0);
      tick(); tick();

      // Out of range below ENTRY, at the top boundary, and the last valid word
      d_req = 1; d_we = 0; d_addr = 32'h7FFF_FFFC;
      tick();
      chk("oor_lo_gnt", 32'({d_gnt, mem_en}), 32'b10);
      d_req = 0;
      tick();
      chk("oor_lo_rv", 32'({d_rvalid, d_err}), 32'b11);
      chk("oor_lo_rd", d_rdata, 32'd0);
      $display("txn read addr=7ffffffc err=%0d", d_err);
      tick();
      d_req = 1; d_we = 1; d_wstrb = 4'hF; d_addr = 32'h8000_2020; d_wdata = 32'h1234_5678;
      tick();
      chk("oor_hi_gnt", 32'({d_gnt, mem_en, mem_we}), 32'b100);
      d_req = 0;
      tick();
      chk("oor_hi_rv", 32'({d_rvalid, d_err}), 32'b11);
      chk("oor_hi_rd", d_rdata, 32'd0);
      $display("txn write addr=80002020 err=%0d", d_err);
      tick();
      d_req = 1; d_we = 0; d_wstrb = 0; d_addr = 32'h8000_201C;
      tick();
      chk("last_men", 32'(mem_en), 32'd1);
      chk("last_idx", mem_idx, 32'd2055);
      d_req = 0;
      tick();
      chk("last_rv", 32'({d_rvalid, d_err}), 32'b10);
      chk("last_rd", d_rdata, 32'hA5A5_0007);
      $display("txn read addr=8000201c rdata=%h", d_rdata);
      tick();

      // MEM_LAT=3: two WAIT cycles, held request re-sampled only after RESP
      b_i_req = 1; b_i_addr = 32'h8000_000C;
      tick();
      chk("l3_gnt", 32'({b_i_gnt, b_mem_en}), 32'b11);
      chk("l3_idx", b_mem_idx, 32'd3);
      tick();
      chk("l3_w1", 32'({b_i_gnt, b_i_rvalid}), 32'b00);
      tick();
      chk("l3_w2", 32'({b_i_gnt, b_i_rvalid}), 32'b00);
      tick();
      chk("l3_rv", 32'({b_i_gnt, b_i_rvalid, b_i_err}), 32'b010);
      chk("l3_rd", b_i_rdata, 32'h3C3C_0003);
      $display("txn lat3 fetch addr=8000000c rdata=%h", b_i_rdata);
      tick();
      chk("l3_idle", 32'({b_i_gnt, b_i_rvalid}), 32'b00);
      tick();
      chk("l3_regnt", 32'(b_i_gnt), 32'd1);
      b_i_req = 0;
      tick(); tick(); tick();
      chk("l3_rv2", 32'(b_i_rvalid), 32'd1);
      tick();

      // Reset during WAIT abandons the fetch
      b_i_req = 1; b_i_addr = 32'h8000_0010;
      tick();
      chk("rw_gnt", 32'(b_i_gnt), 32'd1);
      b_i_req = 0;
      tick();
      reset = 1'b1;
      tick();
      chk("rw_ctl", 32'({b_i_gnt, b_i_rvalid, b_i_err, b_d_gnt, b_d_rvalid, b_d_err,
                         b_mem_en, b_mem_we, b_mem_wstrb}), 32'd0);
      chk("rw_data", b_i_rdata | b_d_rdata | b_mem_idx | b_mem_wdata, 32'd0);
      reset = 1'b0;
      n_rv = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (b_i_rvalid) n_rv++;
      end
      chk("rw_no_rv", 32'(n_rv), 32'd0);
      b_i_req = 1; b_i_addr = 32'h8000_0014;
      tick();
      chk("rw_new_gnt", 32'(b_i_gnt), 32'd1);
      b_i_req = 0;
      tick(); tick(); tick();
      chk("rw_new_rv", 32'(b_i_rvalid), 32'd1);
      chk("rw_new_rd", b_i_rdata, 32'h3C3C_0005);
      $display("txn lat3 fetch after reset rdata=%h", b_i_rdata);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
